// File: rtl/frame_req_arbiter.sv
// frame_req_arbiter: round-robin, packet-locked arbiter for a NoC ingress port.
// Optional macro FRAME_ARB_READ_PRIORITY_EN: read sop requests win over write sop.
module frame_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AVL_DATA_WIDTH = 512,
  parameter int FRAME_ID_WIDTH = 32,
  parameter int FRAME_OFFSET_WIDTH = 5,
  parameter int WIDTH_PKT = AVL_DATA_WIDTH + 2 + FRAME_ID_WIDTH,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*AVL_DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ-1:0]                 req_read,
  input  logic [NUM_REQ*FRAME_ID_WIDTH-1:0]  req_frame_id,
  input  logic [NUM_REQ-1:0]                 req_sop,
  input  logic [NUM_REQ-1:0]                 req_eop,
  output logic [WIDTH_PKT-1:0]               noc_data_in,
  output logic [3:0]                         noc_valid_in,
  input  logic                               noc_ready_out,
  output logic [3:0]                         noc_sop_in,
  output logic [3:0]                         noc_eop_in,
  output logic [GW-1:0]                      grant_id,
  output logic                               proto_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [GW-1:0] g_q, g_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [GW-1:0] win;
  logic [FRAME_OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic ov_q, ov_d;
  logic osop_q, osop_d;
  logic oeop_q, oeop_d;
  logic [WIDTH_PKT-1:0] od_q, od_d;

  logic hit;
  logic [NUM_REQ-1:0] cand;
  logic [AVL_DATA_WIDTH-1:0] s_data;
  logic [FRAME_ID_WIDTH-1:0] s_fid;
  logic s_valid;
  logic s_eop;
  logic s_wr;
  logic s_rd;
  logic out_free;
  logic accept;
  logic last;
  logic end_pkt;
  logic [GW-1:0] rr_next;

  // Beat fields of the currently granted requester.
  always_comb begin
    s_data  = req_data[int'(g_q)*AVL_DATA_WIDTH +: AVL_DATA_WIDTH];
    s_fid   = req_frame_id[int'(g_q)*FRAME_ID_WIDTH +: FRAME_ID_WIDTH];
    s_valid = req_valid[g_q];
    s_eop   = req_eop[g_q];
    s_wr    = req_write[g_q];
    s_rd    = req_read[g_q];
  end

  // Round-robin search over sop requesters starting at rr_q.
  always_comb begin
    int idx;
    cand = req_valid & req_sop;
`ifdef FRAME_ARB_READ_PRIORITY_EN
    if (|(cand & req_read)) begin
      cand = cand & req_read;
    end
`endif
    hit = 1'b0;
    win = '0;
    idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!hit && cand[idx]) begin
        hit = 1'b1;
        win = GW'(idx);
      end
    end
  end

  assign out_free = !ov_q || noc_ready_out;
  assign accept   = (state_q == STREAM) && s_valid && out_free;
  assign last     = (cnt_q == {FRAME_OFFSET_WIDTH{1'b1}});
  assign end_pkt  = s_eop || last || s_rd;
  assign rr_next  = (g_q == GW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;

  assign req_ready = (state_q == STREAM && out_free && !rst)
                   ? (NUM_REQ'(1) << g_q) : '0;

  // Next state: arbitration, beat acceptance and output register load.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ov_d    = ov_q;
    osop_d  = osop_q;
    oeop_d  = oeop_q;
    od_d    = od_q;
    if (ov_q && noc_ready_out) begin
      ov_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (|(req_valid & ~req_sop)) begin
          err_d = 1'b1;
        end
        if (hit) begin
          g_d     = win;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          ov_d   = 1'b1;
          od_d   = {s_wr, s_rd, s_fid, s_data};
          osop_d = (cnt_q == '0);
          oeop_d = end_pkt;
          cnt_d  = cnt_q + 1'b1;
          if ((!s_eop && (last || s_rd)) || (s_rd && s_wr)) begin
            err_d = 1'b1;
          end
          if (end_pkt) begin
            state_d = IDLE;
            rr_d    = rr_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any partial packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      osop_q  <= 1'b0;
      oeop_q  <= 1'b0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      osop_q  <= osop_d;
      oeop_q  <= oeop_d;
      od_q    <= od_d;
    end
  end

  assign noc_data_in  = od_q;
  assign noc_valid_in = {4{ov_q}};
  assign noc_sop_in   = {3'b000, osop_q & ov_q};
  assign noc_eop_in   = {oeop_q & ov_q, 3'b000};
  assign grant_id     = g_q;
  assign proto_err    = err_q;

endmodule
